// File: rtl/btn_debounce_bank_if.sv
// Button bank bus: raw pins and repeat mask in, debounced level and strobes out.
// Latency: none (wires only).
// Backpressure: none; outputs are level/strobe signals consumed every cycle.
interface btn_debounce_bank_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] i_buttons;
  logic [N_BTN-1:0] i_repeat_mask;
  logic [N_BTN-1:0] o_level;
  logic [N_BTN-1:0] o_pulse;
  logic             o_any;

  modport master (
    output i_buttons, i_repeat_mask,
    input  o_level, o_pulse, o_any
  );

  modport slave (
    input  i_buttons, i_repeat_mask,
    output o_level, o_pulse, o_any
  );
endinterface

// File: rtl/btn_debounce_bank.sv
// N-channel button conditioner: 2-flop sync, stability-count debounce, press/auto-repeat strobe.
// Latency: clean edge -> o_level/o_pulse after 2+STABLE_CYCLES clocks; repeats every REPEAT_PERIOD.
// Backpressure: none. Define BTN_DEBOUNCE_ONEHOT_EN to keep only the lowest-index strobe per cycle.
module btn_debounce_bank #(
  parameter int N_BTN         = 5,
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input logic                clk,
  input logic                rst,
  btn_debounce_bank_if.slave bus
);

  localparam int DCW  = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(STABLE_CYCLES - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_LAST = RCW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DELAY, ST_REPEAT} state_e;

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] s_q, s_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] cand;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic             any_q, any_d;

  // Two-stage synchroniser; nothing else looks at the raw pins.
  always_comb begin
    sync1_d = bus.i_buttons;
    s_d     = sync1_q;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [DCW-1:0] dc_q, dc_d;
    logic [RCW-1:0] rc_q, rc_d;
    state_e         st_q, st_d;
    logic           lvl_d;
    logic           cand_c;
    logic           rise, fall;

    // Debounce: accept the synchronised level after STABLE_CYCLES consecutive differing cycles.
    always_comb begin
      dc_d  = '0;
      lvl_d = level_q[g];
      if (s_q[g] != level_q[g]) begin
        if (dc_q == DC_LAST) begin
          lvl_d = s_q[g];
        end else begin
          dc_d = dc_q + DCW'(1);
        end
      end
    end

    // Repeat FSM: press strobe on the rising level, then delayed/periodic strobes while held and masked in.
    always_comb begin
      st_d   = st_q;
      rc_d   = rc_q;
      cand_c = 1'b0;
      rise   = !level_q[g] && lvl_d;
      fall   = level_q[g] && !lvl_d;
      case (st_q)
        ST_IDLE: begin
          if (rise) begin
            cand_c = 1'b1;
            rc_d   = '0;
            st_d   = bus.i_repeat_mask[g] ? ST_DELAY : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (fall) st_d = ST_IDLE;
        end
        ST_DELAY, ST_REPEAT: begin
          // Release wins over a coinciding repeat; a dropped mask parks the channel until re-press.
          if (fall) begin
            st_d = ST_IDLE;
            rc_d = '0;
          end else if (!bus.i_repeat_mask[g]) begin
            st_d = ST_HOLD;
            rc_d = '0;
          end else if (rc_q == ((st_q == ST_DELAY) ? RD_LAST : RP_LAST)) begin
            cand_c = 1'b1;
            rc_d   = '0;
            st_d   = ST_REPEAT;
          end else begin
            rc_d = rc_q + RCW'(1);
          end
        end
        default: begin
          st_d = ST_IDLE;
          rc_d = '0;
        end
      endcase
    end

    assign level_d[g] = lvl_d;
    assign cand[g]    = cand_c;

    // Per-channel counters and FSM state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dc_q <= '0;
        rc_q <= '0;
        st_q <= ST_IDLE;
      end else begin
        dc_q <= dc_d;
        rc_q <= rc_d;
        st_q <= st_d;
      end
    end
  end

  // Strobe selection: pass all candidates, or keep only the lowest index when one-hot is required.
  always_comb begin
    pulse_d = cand;
`ifdef BTN_DEBOUNCE_ONEHOT_EN
    pulse_d = cand & (~cand + N_BTN'(1));
`endif
    any_d = |pulse_d;
  end

  // Shared registers: synchroniser, debounced level and output strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      s_q     <= '0;
      level_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      any_q   <= any_d;
    end
  end

  assign bus.o_level = level_q;
  assign bus.o_pulse = pulse_q;
  assign bus.o_any   = any_q;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Bench for btn_debounce_bank: directed scenarios plus random pin activity,
// checked every cycle against a timing model kept in a scoreboard queue.
module tb_btn_debounce_bank;
  localparam int N  = 5;
  localparam int SC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_debounce_bank_if #(.N_BTN(N)) bif ();

  btn_debounce_bank #(
    .N_BTN(N), .STABLE_CYCLES(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] pls;
    logic         any;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pulse_cnt [N] = '{default: 0};

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: pins reach the debouncer two edges late; a level is accepted after
  // SC consecutive differing samples; strobes at press and at press+RD+k*RP while held
  // with the mask continuously set; release never strobes.
  initial begin : model
    logic [N-1:0] r1, r2, sold, lvl, rep_ok, cand, pls;
    int run [N];
    int press [N];
    int cyc;
    logic nl;
    int t;
    r1 = '0; r2 = '0; lvl = '0; rep_ok = '0; cyc = 0;
    for (int i = 0; i < N; i++) begin run[i] = 0; press[i] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        r1 = '0; r2 = '0; lvl = '0; rep_ok = '0;
        for (int i = 0; i < N; i++) run[i] = 0;
      end else begin
        sold = r2;
        r2   = r1;
        r1   = bif.i_buttons;
        cand = '0;
        for (int i = 0; i < N; i++) begin
          nl = lvl[i];
          if (sold[i] != lvl[i]) begin
            run[i]++;
            if (run[i] == SC) begin
              nl     = sold[i];
              run[i] = 0;
            end
          end else begin
            run[i] = 0;
          end
          if (!lvl[i] && nl) begin
            cand[i]   = 1'b1;
            press[i]  = cyc;
            rep_ok[i] = bif.i_repeat_mask[i];
          end else if (lvl[i] && nl) begin
            if (!bif.i_repeat_mask[i]) rep_ok[i] = 1'b0;
            else if (rep_ok[i]) begin
              t = cyc - press[i];
              if (t >= RD && ((t - RD) % RP) == 0) cand[i] = 1'b1;
            end
          end else begin
            rep_ok[i] = 1'b0;
          end
          lvl[i] = nl;
        end
        pls = cand;
`ifdef BTN_DEBOUNCE_ONEHOT_EN
        for (int i = N - 1; i >= 0; i--) if (cand[i]) pls = N'(1) << i;
`endif
        expq.push_back('{lvl: lvl, pls: pls, any: |pls});
      end
    end
  end

  // Monitor: outputs must be zero in reset; otherwise match the oldest expected entry.
  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      a = '{lvl: bif.o_level, pls: bif.o_pulse, any: bif.o_any};
      if (!rst) begin
        expq.delete();
        chk("reset_outputs", int'(a), 0);
      end else if (expq.size() > 0) begin
        e = expq.pop_front();
        chk($sformatf("outputs@%0t", $time), int'(a), int'(e));
        for (int i = 0; i < N; i++) if (bif.o_pulse[i]) pulse_cnt[i]++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : driver
    int c0, c1, c2, c3;
    bif.i_buttons     = '0;
    bif.i_repeat_mask = '0;
    #1 rst = 1'b0;

    // Reset with every pin pressed, then release: one press strobe on each channel.
    bif.i_buttons = '1;
    tick(3);
    rst = 1'b1;
    tick(10);
    for (int i = 0; i < N; i++) chk($sformatf("reset_release_press%0d", i), pulse_cnt[i], 1);
    bif.i_buttons = '0;
    tick(12);

    // Bounce shorter than the stability window, then a clean hold.
    c0 = pulse_cnt[0];
    repeat (10) begin
      bif.i_buttons[0] = 1'b1; tick(3);
      bif.i_buttons[0] = 1'b0; tick(3);
    end
    chk("bounce_no_pulse", pulse_cnt[0] - c0, 0);
    bif.i_buttons[0] = 1'b1; tick(20);
    chk("bounce_then_hold", pulse_cnt[0] - c0, 1);
    bif.i_buttons[0] = 1'b0; tick(12);

    // Auto-repeat for 100 held cycles: press + 10 repeats, release suppresses the coinciding one.
    bif.i_repeat_mask = 5'h01;
    c0 = pulse_cnt[0];
    bif.i_buttons[0] = 1'b1; tick(100);
    bif.i_buttons[0] = 1'b0; tick(12);
    chk("repeat_count", pulse_cnt[0] - c0, 11);

    // Long hold without repeat enabled.
    bif.i_repeat_mask = '0;
    c1 = pulse_cnt[1];
    bif.i_buttons[1] = 1'b1; tick(200);
    bif.i_buttons[1] = 1'b0; tick(12);
    chk("no_repeat_count", pulse_cnt[1] - c1, 1);

    // Mask dropped mid-repeat: stops after the first repeat until re-press.
    bif.i_repeat_mask = 5'h01;
    c0 = pulse_cnt[0];
    bif.i_buttons[0] = 1'b1; tick(30);
    bif.i_repeat_mask = '0; tick(70);
    chk("mask_drop_count", pulse_cnt[0] - c0, 2);
    bif.i_buttons[0] = 1'b0; tick(12);
    bif.i_buttons[0] = 1'b1; tick(10);
    chk("mask_drop_repress", pulse_cnt[0] - c0, 3);
    bif.i_buttons[0] = 1'b0; tick(12);

    // Simultaneous presses on channels 1 and 3.
    c1 = pulse_cnt[1];
    c3 = pulse_cnt[3];
    bif.i_buttons = 5'b01010; tick(20);
    chk("simul_ch1", pulse_cnt[1] - c1, 1);
`ifdef BTN_DEBOUNCE_ONEHOT_EN
    chk("simul_ch3", pulse_cnt[3] - c3, 0);
`else
    chk("simul_ch3", pulse_cnt[3] - c3, 1);
`endif
    bif.i_buttons = '0; tick(12);

    // Reset while a button is held: fresh press strobe after release of reset.
    c2 = pulse_cnt[2];
    bif.i_buttons[2] = 1'b1; tick(20);
    rst = 1'b0; tick(2);
    rst = 1'b1; tick(10);
    chk("reset_mid_hold", pulse_cnt[2] - c2, 2);
    bif.i_buttons[2] = 1'b0; tick(12);

    // Random pin activity and mask changes, with one reset in the middle.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(29) == 0) bif.i_buttons[i] = ~bif.i_buttons[i];
        if ($urandom_range(59) == 0) bif.i_repeat_mask[i] = ~bif.i_repeat_mask[i];
      end
      if (k == 1500) begin
        rst = 1'b0; tick(3);
        rst = 1'b1;
      end
      tick(1);
    end
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
